// File: rtl/matmul_mmio_pkg.sv
// Shared definitions for the matmul MMIO front end: register offsets, CTRL bits, decode regions
// and FSM states.
package matmul_mmio_pkg;

  localparam logic [11:0] CTRL_OFF = 12'h000;
  localparam logic [11:0] ROWA_OFF = 12'h100;
  localparam logic [11:0] MATB_OFF = 12'h400;
  localparam logic [11:0] ROWC_OFF = 12'h800;

  // CTRL write bits
  localparam int unsigned CTRL_START    = 0;
  localparam int unsigned CTRL_CLR_DONE = 1;
  localparam int unsigned CTRL_CLR_ERR  = 2;

  typedef enum logic [2:0] {
    RegNone,
    RegCtrl,
    RegRowA,
    RegMatB,
    RegRowC
  } region_e;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

endpackage

// File: rtl/matmul_mmio_if.sv
// PicoRV32 native memory bus, as seen by one peripheral.
interface matmul_mmio_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/matmul_mmio_decode.sv
// Combinational offset decoder: word offset -> region, element index and hi/lo result word.
// Offsets past the end of a region decode as RegNone.
module matmul_mmio_decode
  import matmul_mmio_pkg::*;
#(
  parameter int unsigned CW = 8,
  parameter int unsigned CH = 8
) (
  input  logic [9:0] word_i,
  output region_e    region_o,
  output logic [9:0] idx_o,
  output logic       hi_o
);

  localparam logic [9:0] CtrlW = CTRL_OFF[11:2];
  localparam logic [9:0] RowAW = ROWA_OFF[11:2];
  localparam logic [9:0] MatBW = MATB_OFF[11:2];
  localparam logic [9:0] RowCW = ROWC_OFF[11:2];

  logic [9:0] rel_a, rel_b, rel_c;

  assign rel_a = word_i - RowAW;
  assign rel_b = word_i - MatBW;
  assign rel_c = word_i - RowCW;

  // Region select with per-region bound check; row C uses two words per element
  always_comb begin
    region_o = RegNone;
    idx_o    = '0;
    hi_o     = 1'b0;
    if (word_i == CtrlW) begin
      region_o = RegCtrl;
    end else if (word_i >= RowAW && word_i < MatBW) begin
      if ({22'd0, rel_a} < CW) begin
        region_o = RegRowA;
        idx_o    = rel_a;
      end
    end else if (word_i >= MatBW && word_i < RowCW) begin
      if ({22'd0, rel_b} < CW * CH) begin
        region_o = RegMatB;
        idx_o    = rel_b;
      end
    end else if (word_i >= RowCW) begin
      if ({23'd0, rel_c[9:1]} < CW) begin
        region_o = RegRowC;
        idx_o    = {1'b0, rel_c[9:1]};
        hi_o     = rel_c[0];
      end
    end
  end

endmodule

// File: rtl/matmul_mmio.sv
// Memory-mapped front end for the matmul accelerator. Operands are buffered and driven as flat
// buses; START waits SETTLE_CYCLES for the combinational accelerator, then captures row C.
module matmul_mmio
  import matmul_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'h0200_0000,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned CHUNK_WIDTH   = 8,
  parameter int unsigned CHUNK_HEIGHT  = 8,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                                         clk,
  input  logic                                         reset,
  matmul_mmio_if.slave                                 bus,
  output logic [CHUNK_WIDTH*DATA_WIDTH-1:0]              row_a_o,
  output logic [CHUNK_WIDTH*CHUNK_HEIGHT*DATA_WIDTH-1:0] matrix_b_o,
  input  logic [CHUNK_WIDTH*2*DATA_WIDTH-1:0]            row_c_i,
  output logic                                         done_irq
);

  localparam int unsigned DW   = DATA_WIDTH;
  localparam int unsigned CW   = CHUNK_WIDTH;
  localparam int unsigned CH   = CHUNK_HEIGHT;
  localparam int unsigned RW   = 2 * DW;
  localparam int unsigned NB   = CW * CH;
  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  region_e         region;
  logic [9:0]      idx;
  logic            hi;
  logic            sel, accept, wr, busy;
  logic            ctrl_wr, start, clr_done, clr_err;
  logic            rowa_we, matb_we, op_blocked, capture;
  logic            ready_q, ready_d;
  logic [31:0]     rdata_q, rdata_d;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            done_q, done_d, err_q, err_d, irq_q, irq_d;
  logic [DW-1:0]   rowa_q [CW];
  logic [DW-1:0]   matb_q [NB];
  logic [RW-1:0]   rowc_q [CW];
  logic [DW-1:0]   rowa_cur, matb_cur;
  logic [RW-1:0]   rowc_cur;
  logic [63:0]     rowc_ext;
  logic            unused_addr;

  // Byte lanes beyond DW fall off the top when truncating
  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_val,
                                                input logic [31:0]   wdata,
                                                input logic [3:0]    strb);
    logic [31:0] w;
    w = 32'(old_val);
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) w[8*b +: 8] = wdata[8*b +: 8];
    end
    return w[DW-1:0];
  endfunction

  matmul_mmio_decode #(
    .CW(CW),
    .CH(CH)
  ) u_decode (
    .word_i  (bus.mem_addr[11:2]),
    .region_o(region),
    .idx_o   (idx),
    .hi_o    (hi)
  );

  assign unused_addr = ^bus.mem_addr[1:0];

  assign sel     = bus.mem_valid && (bus.mem_addr[31:12] == BASE_ADDR[31:12]);
  assign accept  = sel && !ready_q;
  assign ready_d = accept;
  assign wr      = accept && (bus.mem_wstrb != 4'b0000);
  assign busy    = (state_q == StRun);

  assign ctrl_wr    = wr && (region == RegCtrl) && bus.mem_wstrb[0];
  assign start      = ctrl_wr && bus.mem_wdata[CTRL_START];
  assign clr_done   = ctrl_wr && bus.mem_wdata[CTRL_CLR_DONE];
  assign clr_err    = ctrl_wr && bus.mem_wdata[CTRL_CLR_ERR];
  assign rowa_we    = wr && (region == RegRowA) && !busy;
  assign matb_we    = wr && (region == RegMatB) && !busy;
  assign op_blocked = wr && ((region == RegRowA) || (region == RegMatB)) && busy;

  // Element mux for read-back and read-modify-write of partial strobes
  always_comb begin
    rowa_cur = '0;
    matb_cur = '0;
    rowc_cur = '0;
    for (int i = 0; i < CW; i++) begin
      if (idx == 10'(i)) begin
        rowa_cur = rowa_q[i];
        rowc_cur = rowc_q[i];
      end
    end
    for (int i = 0; i < NB; i++) begin
      if (idx == 10'(i)) matb_cur = matb_q[i];
    end
  end

  assign rowc_ext = 64'(rowc_cur);

  // Read data is registered alongside the ready pulse
  always_comb begin
    rdata_d = rdata_q;
    if (accept) begin
      case (region)
        RegCtrl: rdata_d = {29'd0, err_q, done_q, busy};
        RegRowA: rdata_d = 32'(rowa_cur);
        RegMatB: rdata_d = 32'(matb_cur);
        RegRowC: rdata_d = hi ? rowc_ext[63:32] : rowc_ext[31:0];
        default: rdata_d = '0;
      endcase
    end
  end

  // Next-state: clears apply first so capture and error-setting events win
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    err_d   = err_q;
    irq_d   = 1'b0;
    capture = 1'b0;
    if (clr_done) done_d = 1'b0;
    if (clr_err) err_d = 1'b0;
    if (op_blocked) err_d = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          cnt_d   = CntW'(SETTLE_CYCLES - 1);
          done_d  = 1'b0;
        end
      end
      StRun: begin
        if (start) err_d = 1'b1;
        if (cnt_q == '0) begin
          capture = 1'b1;
          done_d  = 1'b1;
          irq_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and bus response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      irq_q   <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      irq_q   <= irq_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  // Operand buffers written from the bus, result buffer loaded on capture
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CW; i++) rowa_q[i] <= '0;
      for (int i = 0; i < NB; i++) matb_q[i] <= '0;
      for (int i = 0; i < CW; i++) rowc_q[i] <= '0;
    end else begin
      for (int i = 0; i < CW; i++) begin
        if (rowa_we && idx == 10'(i)) begin
          rowa_q[i] <= merge_bytes(rowa_cur, bus.mem_wdata, bus.mem_wstrb);
        end
      end
      for (int i = 0; i < NB; i++) begin
        if (matb_we && idx == 10'(i)) begin
          matb_q[i] <= merge_bytes(matb_cur, bus.mem_wdata, bus.mem_wstrb);
        end
      end
      for (int i = 0; i < CW; i++) begin
        if (capture) rowc_q[i] <= row_c_i[i*RW +: RW];
      end
    end
  end

  for (genvar g = 0; g < CW; g++) begin : g_row_a
    assign row_a_o[g*DW +: DW] = rowa_q[g];
  end

  for (genvar g = 0; g < NB; g++) begin : g_mat_b
    assign matrix_b_o[g*DW +: DW] = matb_q[g];
  end

  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;
  assign done_irq      = irq_q;

endmodule

// File: tb/tb_matmul_mmio.sv
// Directed bench for matmul_mmio with a behavioural matmul stub on row_c_i.
module tb_matmul_mmio;

  localparam logic [31:0] BASE = 32'h0200_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic [255:0]  row_a;
  logic [2047:0] matb;
  logic [511:0]  row_c;
  logic          done_irq;

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int irq_count = 0;
  int irq_cyc   = 0;
  int ready_cyc = 0;
  int start_cyc = 0;
  int seen      = 0;

  always #5 clk = ~clk;

  matmul_mmio_if bus ();

  matmul_mmio #(
    .BASE_ADDR    (BASE),
    .DATA_WIDTH   (32),
    .CHUNK_WIDTH  (8),
    .CHUNK_HEIGHT (8),
    .SETTLE_CYCLES(2)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .row_a_o   (row_a),
    .matrix_b_o(matb),
    .row_c_i   (row_c),
    .done_irq  (done_irq)
  );

  // Accelerator stub: C[k] = sum_i A[i] * B[i][k], truncated to 64 bits
  always_comb begin
    row_c = '0;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 8; i++) begin
        row_c[k*64 +: 64] = row_c[k*64 +: 64]
                          + 64'(row_a[i*32 +: 32]) * 64'(matb[(i*8+k)*32 +: 32]);
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done_irq === 1'b1) begin
      irq_count <= irq_count + 1;
      irq_cyc   <= cyc;
    end
  end

  function automatic logic [31:0] a_addr(input int i);
    return BASE + 32'h100 + 32'(4 * i);
  endfunction

  function automatic logic [31:0] b_addr(input int i, input int j);
    return BASE + 32'h400 + 32'(4 * (i * 8 + j));
  endfunction

  function automatic logic [31:0] c_lo(input int k);
    return BASE + 32'h800 + 32'(8 * k);
  endfunction

  function automatic logic [31:0] c_hi(input int k);
    return BASE + 32'h804 + 32'(8 * k);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bus transaction; called #1 after a posedge, returns #1 after a posedge
  task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, output logic [31:0] rdata);
    int n = 0;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    bus.mem_wstrb = strb;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bus.mem_ready !== 1'b1 && n < 8);
    ready_cyc     = cyc;
    rdata         = bus.mem_rdata;
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'b0000;
    check($sformatf("ready_latency@%h", addr), 64'(n), 64'd1);
    @(posedge clk);
    #1;
    check($sformatf("ready_pulse@%h", addr), {63'd0, bus.mem_ready}, 64'd0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] strb = 4'hF);
    logic [31:0] d;
    xfer(addr, data, strb, d);
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    xfer(addr, 32'd0, 4'd0, d);
    check(tag, 64'(d), 64'(exp));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    idle(3);
    check("reset_ready", {63'd0, bus.mem_ready}, 64'd0);
    check("reset_rdata", 64'(bus.mem_rdata), 64'd0);
    check("reset_irq", {63'd0, done_irq}, 64'd0);
    reset = 1'b0;
    idle(1);
    check("reset_row_a", {63'd0, |row_a}, 64'd0);
    check("reset_mat_b", {63'd0, |matb}, 64'd0);

    // Reset read-back and handshake
    rd("ctrl_reset", BASE, 32'd0);
    rd("rowa3_reset", a_addr(3), 32'd0);
    rd("rowc0_hi_reset", c_hi(0), 32'd0);
    bus.mem_valid = 1'b1;
    bus.mem_addr  = BASE;
    idle(1);
    check("held_valid_first", {63'd0, bus.mem_ready}, 64'd1);
    idle(1);
    check("held_valid_no_repeat", {63'd0, bus.mem_ready}, 64'd0);
    bus.mem_valid = 1'b0;
    idle(1);
    check("irq_none_yet", 64'(irq_count), 64'd0);

    // Identity B: C = A
    for (int i = 0; i < 8; i++) begin
      wr(a_addr(i), 32'(i + 1));
      wr(b_addr(i, i), 32'd1);
    end
    wr(BASE, 32'h1);
    start_cyc = ready_cyc;
    rd("busy_in_run", BASE, 32'h1);
    idle(3);
    check("irq_count_run1", 64'(irq_count), 64'd1);
    check("irq_latency", 64'(irq_cyc - start_cyc), 64'd2);
    rd("ctrl_done", BASE, 32'h2);
    rd("rowc5_lo", c_lo(5), 32'd6);
    rd("rowc5_hi", c_hi(5), 32'd0);

    // Full-width product: 0xFFFFFFFF squared
    wr(a_addr(0), 32'hFFFF_FFFF);
    wr(b_addr(0, 0), 32'hFFFF_FFFF);
    wr(BASE, 32'h1);
    idle(4);
    rd("rowc0_lo_sq", c_lo(0), 32'h0000_0001);
    rd("rowc0_hi_sq", c_hi(0), 32'hFFFF_FFFE);
    check("irq_count_run2", 64'(irq_count), 64'd2);

    // Byte strobe merge
    wr(a_addr(2), 32'h1122_3344);
    wr(a_addr(2), 32'h0000_AB00, 4'b0010);
    rd("rowa2_byte", a_addr(2), 32'h1122_AB44);

    // START together with clear-DONE: START wins
    wr(BASE, 32'h3);
    rd("start_clr_done", BASE, 32'h1);
    idle(4);
    rd("start_clr_done_end", BASE, 32'h2);

    // Clear-DONE lands in the capture cycle: capture wins
    wr(BASE, 32'h1);
    wr(BASE, 32'h2);
    idle(3);
    rd("clr_done_at_capture", BASE, 32'h2);
    check("irq_count_run4", 64'(irq_count), 64'd4);

    // Operand write during RUN is discarded and flags ERR
    wr(BASE, 32'h1);
    wr(b_addr(0, 0), 32'h5);
    idle(3);
    rd("err_op_write", BASE, 32'h6);
    rd("matb00_kept", b_addr(0, 0), 32'hFFFF_FFFF);
    wr(BASE, 32'h4);
    rd("err_cleared1", BASE, 32'h2);

    // START during RUN flags ERR, single done_irq
    wr(BASE, 32'h1);
    wr(BASE, 32'h1);
    idle(4);
    rd("err_start_busy", BASE, 32'h6);
    check("irq_count_run6", 64'(irq_count), 64'd6);
    wr(BASE, 32'h4);
    rd("err_cleared2", BASE, 32'h2);

    // Reset one cycle before capture
    wr(BASE, 32'h1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(3);
    check("irq_after_reset", 64'(irq_count), 64'd6);
    rd("ctrl_after_reset", BASE, 32'd0);
    rd("rowc0_after_reset", c_lo(0), 32'd0);
    rd("rowa1_after_reset", a_addr(1), 32'd0);

    // Unmapped in-window offsets respond with zero
    rd("hole_0fc", BASE + 32'h0FC, 32'd0);
    wr(BASE + 32'h120, 32'hDEAD_BEEF);
    rd("hole_120", BASE + 32'h120, 32'd0);

    // Out-of-window access gets no response
    bus.mem_valid = 1'b1;
    bus.mem_addr  = BASE + 32'h1000;
    bus.mem_wstrb = 4'b0000;
    seen = 0;
    repeat (5) begin
      idle(1);
      if (bus.mem_ready === 1'b1) seen++;
    end
    bus.mem_valid = 1'b0;
    check("out_of_window", 64'(seen), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matmul_mmio.md
Name: matmul_mmio

Overview:
- Memory-mapped front end for the matmul accelerator; sits on the PicoRV32 native memory bus, directly upstream and downstream of the accelerator.
- CPU stores row A and matrix B operands into buffers; the block drives them to the accelerator as flat buses.
- On START, waits a programmable settle latency, captures row C into result registers and raises done; CPU reads results back over the bus.

Parameters:
- BASE_ADDR, 32'h0200_0000, base of the 4 KiB register window; bits [11:0] must be zero.
- DATA_WIDTH, 32, operand element width; must be ≤32. Result element width is 2*DATA_WIDTH.
- CHUNK_WIDTH, 8, row A length and row C length (CW).
- CHUNK_HEIGHT, 8, matrix B columns per row (CH).
- SETTLE_CYCLES, 2, cycles from START acceptance to result capture; must be ≥1 (multicycle path through the combinational accelerator).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- mem_valid  in  1  bus request.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte strobes; 0 means read.
- mem_ready  out  1  response pulse.
- mem_rdata  out  32  read data.
- row_a_o  out  CW*DW  element i at bits [i*DW +: DW].
- matrix_b_o  out  CW*CH*DW  element (i,j) at index (i*CH+j)*DW.
- row_c_i  in  CW*2*DW  accelerator result; element k at [k*2*DW +: 2*DW].
- done_irq  out  1  one-cycle pulse on capture.

Behaviour:
- Reset, which takes priority over all other activity: mem_ready=0, mem_rdata=0, done_irq=0, state=IDLE, all operand and result buffers 0, status bits 0.
- Select: sel = mem_valid && mem_addr[31:12]==BASE_ADDR[31:12]. Out-of-window accesses get no response; mem_ready stays 0.
- Handshake:
  - mem_ready <= sel && !mem_ready, so it is a single-cycle pulse, one cycle after valid.
  - The write takes effect and mem_rdata is registered in the same cycle mem_ready is set.
  - A held mem_valid after ready produces no second response.
- Address map (offset = mem_addr[11:0], word aligned; addr[1:0] ignored):
  - 0x000 CTRL. Write bit0=1 issues START. Write bit1=1 clears DONE. Write bit2=1 clears ERR. Read returns {29'b0, ERR, DONE, BUSY}.
  - 0x100 + 4*i, i<CW: row_a[i].
  - 0x400 + 4*(i*CH+j): matrix_b[i][j].
  - 0x800 + 8*k: row_c[k] low word. 0x804 + 8*k: row_c[k] high word. Read-only.
  - Any other in-window offset: read 0, write ignored, ready still returned.
- Widths:
  - Operand writes honour mem_wstrb per byte. Bytes beyond DATA_WIDTH are discarded.
  - Operand reads are zero-extended.
  - When DATA_WIDTH < 32, the high result word carries bits [2*DW-1:32] if 2*DW > 32; otherwise it reads 0.
- FSM:
  - IDLE: START moves to RUN, loads cnt=SETTLE_CYCLES-1 and clears DONE.
  - RUN: BUSY=1. cnt decrements each cycle. At cnt==0, row_c_i is captured into the result registers, DONE=1, done_irq pulses, and the state returns to IDLE.
  - Capture therefore occurs exactly SETTLE_CYCLES cycles after the mem_ready cycle of the START write.
- Boundary rules:
  - START while BUSY: ignored, ERR=1.
  - Operand write while BUSY: discarded, ERR=1, ready still returned.
  - Reads while BUSY: allowed; result regions return the previous capture.
  - CTRL write with START and clear-DONE together: START wins and DONE ends 0.
  - Clear-DONE in the capture cycle: capture wins, DONE=1.
  - Reset during RUN: returns to IDLE with no capture and no done_irq.
- row_a_o and matrix_b_o are driven directly from the buffers, with no combinational path from the bus.

Decomposition:
- Shared package/header matmul_mmio_defs:
  - Offsets CTRL_OFF, ROWA_OFF, MATB_OFF, ROWC_OFF.
  - CTRL bit positions.
  - State encoding IDLE/RUN.
- One sub-module, matmul_mmio_decode (combinational), covering:
  - Offset → region (CTRL/ROWA/MATB/ROWC/NONE).
  - Element index.
  - Hi/lo word select.
  - In-range check.
- FSM, buffers and bus response stay in matmul_mmio.

Test Plan:
1. Reset, then read CTRL, row_a[3] and row_c[0] high word → all read 0. mem_ready pulses once, one cycle after each valid. done_irq stays 0.
2. Write row_a[i]=i+1 and B = identity (CW=CH=8), START. Model C[k]=A[k] (accelerator stub) → BUSY reads 1 during RUN. done_irq occurs 2 cycles after the START ready. row_c[5] reads lo=6, hi=0.
3. Set A[0]=32'hFFFF_FFFF with the stub returning the 64-bit square → row_c[0] reads lo=32'h0000_0001, hi=32'hFFFF_FFFE.
4. Byte write: wstrb=4'b0010, wdata=32'h0000_AB00 to row_a[2], which held 32'h1122_3344 → reads 32'h1122_AB44.
5. START issued during RUN, plus a write to matrix_b[0][0] during RUN → ERR=1, B unchanged, single done_irq. CTRL write 4 clears ERR.
6. Assert reset one cycle before capture → no done_irq, DONE=0, results 0. Access at BASE_ADDR+32'h1000 → mem_ready never asserts.
